// File: rtl/rr_arb2_pkg.sv
// Shared types and default sizes for the two-input round-robin stream arbiter.
package rr_arb2_pkg;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mux2x1.sv
// Plain 2:1 word multiplexer; sel_i = 1 selects b_i.
module mux2x1 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/rr_arb2_stream.sv
// Two-input round-robin valid/ready arbiter feeding a one-entry registered output,
// with per-source saturating grant counters.
module rr_arb2_stream
  import rr_arb2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             y_valid_o,
  output logic [WIDTH-1:0] y_data_o,
  output logic             y_src_o,
  input  logic             y_ready_i,
  output logic [CNT_W-1:0] a_cnt_o,
  output logic [CNT_W-1:0] b_cnt_o
);

  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q,  y_data_d;
  src_e             y_src_q,   y_src_d;
  src_e             prio_q,    prio_d;
  logic [CNT_W-1:0] a_cnt_q,   a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q,   b_cnt_d;

  logic             load_en;
  logic             grant_a;
  logic             grant_b;
  logic             xfer;
  logic [WIDTH-1:0] mux_y;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_en = !y_valid_q | y_ready_i;
  assign grant_a = a_valid_i & (!b_valid_i | (prio_q == SRC_A));
  assign grant_b = b_valid_i & (!a_valid_i | (prio_q == SRC_B));
  assign xfer    = load_en & (grant_a | grant_b);

  // Gated by rst_ni so no handshake completes while the block is held in reset.
  assign a_ready_o = rst_ni & load_en & grant_a;
  assign b_ready_o = rst_ni & load_en & grant_b;

  mux2x1 #(.WIDTH(WIDTH)) u_mux (
    .a_i  (a_data_i),
    .b_i  (b_data_i),
    .sel_i(grant_b),
    .y_o  (mux_y)
  );

  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_src_d   = y_src_q;
    prio_d    = prio_q;
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    if (load_en) begin
      y_valid_d = grant_a | grant_b;
    end
    if (xfer) begin
      y_data_d = mux_y;
      y_src_d  = grant_b ? SRC_B : SRC_A;
      // Priority always moves to the loser, even when only one side asked.
      prio_d   = grant_b ? SRC_A : SRC_B;
      if (grant_a) a_cnt_d = sat_inc(a_cnt_q);
      else         b_cnt_d = sat_inc(b_cnt_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_src_q   <= SRC_A;
      prio_q    <= SRC_A;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_src_q   <= y_src_d;
      prio_q    <= prio_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;
  assign y_src_o   = y_src_q;
  assign a_cnt_o   = a_cnt_q;
  assign b_cnt_o   = b_cnt_q;

endmodule

// File: tb/tb_rr_arb2_stream.sv
// Bench for rr_arb2_stream: directed scenarios then random traffic, two counter widths.
module tb_rr_arb2_stream;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_valid = 1'b0, b_valid = 1'b0, y_ready = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0;

  logic         a_rdy8, b_rdy8, y_vld8, y_src8;
  logic [W-1:0] y_dat8;
  logic [7:0]   a_cnt8, b_cnt8;
  logic         a_rdy2, b_rdy2, y_vld2, y_src2;
  logic [W-1:0] y_dat2;
  logic [1:0]   a_cnt2, b_cnt2;

  int checks = 0;
  int failures = 0;

  // Reference state: what the output register should hold and totals of grants.
  int       m_vld, m_src, m_prio, m_acnt, m_bcnt;
  logic [W-1:0] m_data;

  always #5 clk = ~clk;

  rr_arb2_stream #(.WIDTH(W), .CNT_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_rdy8),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_rdy8),
    .y_valid_o(y_vld8), .y_data_o(y_dat8), .y_src_o(y_src8), .y_ready_i(y_ready),
    .a_cnt_o(a_cnt8), .b_cnt_o(b_cnt8)
  );

  rr_arb2_stream #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_rdy2),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_rdy2),
    .y_valid_o(y_vld2), .y_data_o(y_dat2), .y_src_o(y_src2), .y_ready_i(y_ready),
    .a_cnt_o(a_cnt2), .b_cnt_o(b_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, " y_valid"}, 32'(y_vld8), 32'(m_vld));
    chk({tag, " y_data"},  32'(y_dat8), 32'(m_data));
    chk({tag, " y_src"},   32'(y_src8), 32'(m_src));
    chk({tag, " a_cnt8"},  32'(a_cnt8), 32'(sat(m_acnt, 255)));
    chk({tag, " b_cnt8"},  32'(b_cnt8), 32'(sat(m_bcnt, 255)));
    chk({tag, " y_data2"}, 32'(y_dat2), 32'(m_data));
    chk({tag, " y_valid2"}, 32'(y_vld2), 32'(m_vld));
    chk({tag, " a_cnt2"},  32'(a_cnt2), 32'(sat(m_acnt, 3)));
    chk({tag, " b_cnt2"},  32'(b_cnt2), 32'(sat(m_bcnt, 3)));
  endtask

  // One clock: check readies mid-cycle, then the registered result after the edge.
  task automatic cycle(input string tag);
    int room, ga, gb;
    logic [W-1:0] a_snap, b_snap;
    @(negedge clk);
    room = (m_vld == 0 || y_ready) ? 1 : 0;
    ga = (a_valid && (!b_valid || m_prio == 0)) ? 1 : 0;
    gb = (b_valid && (!a_valid || m_prio == 1)) ? 1 : 0;
    a_snap = a_data;
    b_snap = b_data;
    chk({tag, " a_ready"},  32'(a_rdy8), 32'(room & ga));
    chk({tag, " b_ready"},  32'(b_rdy8), 32'(room & gb));
    chk({tag, " a_ready2"}, 32'(a_rdy2), 32'(room & ga));
    chk({tag, " b_ready2"}, 32'(b_rdy2), 32'(room & gb));
    @(posedge clk);
    #1;
    if (room == 1) begin
      if (ga == 1 || gb == 1) begin
        m_vld  = 1;
        m_data = (gb == 1) ? b_snap : a_snap;
        m_src  = gb;
        m_prio = (gb == 1) ? 0 : 1;
        if (ga == 1) m_acnt++;
        else         m_bcnt++;
      end else begin
        m_vld = 0;
      end
    end
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_vld = 0; m_src = 0; m_prio = 0; m_acnt = 0; m_bcnt = 0; m_data = '0;
  endtask

  task automatic set_in(input logic av, input logic [W-1:0] ad,
                        input logic bv, input logic [W-1:0] bd, input logic yr);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
  endtask

  // Asserts reset away from clock edges and checks the asynchronous clear.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, " a_ready_in_rst"}, 32'(a_rdy8), 32'(0));
    chk({tag, " b_ready_in_rst"}, 32'(b_rdy8), 32'(0));
    check_outputs(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Inputs valid while in reset: nothing may be accepted.
    set_in(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1);
    @(posedge clk);
    #1;
    do_reset("reset");
    set_in(1'b0, '0, 1'b0, '0, 1'b1);
    cycle("idle");

    set_in(1'b1, 16'hAF70, 1'b0, '0, 1'b1);
    cycle("a_only");
    chk("a_only data", 32'(y_dat8), 32'h0000AF70);
    chk("a_only cnt",  32'(a_cnt8), 32'd1);
    set_in(1'b0, '0, 1'b0, '0, 1'b1);
    cycle("drain");

    do_reset("reset2");
    set_in(1'b1, 16'hCFE0, 1'b1, 16'h7F60, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle("contend");
      chk("contend src", 32'(y_src8), 32'(i % 2));
    end
    chk("contend a_cnt", 32'(a_cnt8), 32'd2);
    chk("contend b_cnt", 32'(b_cnt8), 32'd2);

    set_in(1'b1, 16'hFF00, 1'b0, '0, 1'b1);
    cycle("bp_load");
    set_in(1'b1, 16'h1234, 1'b1, 16'h5678, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_hold");
      chk("bp data", 32'(y_dat8), 32'h0000FF00);
    end
    set_in(1'b1, 16'h1234, 1'b1, 16'h5678, 1'b1);
    cycle("bp_release");
    chk("bp next src", 32'(y_src8), 32'd1);

    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, '0, 1'b1, 16'(16'hB000 + i), 1'b1);
      cycle("b_stream");
      chk("b_stream valid", 32'(y_vld8), 32'd1);
      chk("b_stream data", 32'(y_dat8), 32'(16'hB000 + i));
    end

    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 16'(16'hA500 + i), 1'b0, '0, 1'b1);
      cycle("a_sat");
    end
    chk("sat a_cnt2", 32'(a_cnt2), 32'd3);

    set_in(1'b1, 16'hDEAD, 1'b1, 16'hBEEF, 1'b1);
    #1;
    do_reset("mid_reset");
    cycle("post_reset");
    chk("post_reset src", 32'(y_src8), 32'd0);

    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 16'($urandom),
             1'($urandom_range(0, 1)), 16'($urandom),
             1'($urandom_range(0, 9) < 7));
      cycle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
